// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving a decoded one-hot select for N = 1<<IDX_W requesters.
// Optional forced release after MAX_HOLD cycles: define RR_DECODE_ARBITER_TIMEOUT_EN.
module rr_decode_arbiter #(
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [(1<<IDX_W)-1:0]   req,
   output logic                    gnt_valid,
   output logic [IDX_W-1:0]        gnt_idx,
   output logic [(1<<IDX_W)-1:0]   gnt_onehot,
   output logic                    busy,
   output logic                    timeout
);

   localparam int N = 1 << IDX_W;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] cand;
   logic             found;

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
   localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   logic [HC_W-1:0] hold_cnt;
`endif

   // First requester at or after ptr, wrapping; index arithmetic wraps mod N naturally.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < N; k++) begin
         cand = ptr + IDX_W'(k);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // Both flags come straight from the state register, so they stay registered.
   assign gnt_valid = (state == GRANT);
   assign busy      = (state == GRANT);

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
         hold_cnt   <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (found) begin
                  state      <= GRANT;
                  gnt_idx    <= winner;
                  gnt_onehot <= ONE << winner;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
                  hold_cnt   <= '0;
`endif
               end
            end
            GRANT: begin
               if (!req[gnt_idx]) begin
                  state      <= IDLE;
                  gnt_onehot <= '0;
                  ptr        <= gnt_idx + 1'b1;
               end
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
               else if (hold_cnt == HC_W'(MAX_HOLD - 1)) begin
                  state      <= IDLE;
                  gnt_onehot <= '0;
                  ptr        <= gnt_idx + 1'b1;
                  timeout    <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef RR_DECODE_ARBITER_TIMEOUT_EN
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural round-robin model.
module tb_rr_decode_arbiter;

   localparam int IDX_W    = 3;
   localparam int N        = 1 << IDX_W;
   localparam int MAX_HOLD = 16;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic [N-1:0]     gnt_onehot;
   logic             busy;
   logic             timeout;

   int n_vec;
   int n_err;

   // Reference model state: who owns the grant, where the scan starts next.
   bit m_valid;
   int m_idx;
   int m_ptr;
   int m_hold;
   bit m_timeout;

   rr_decode_arbiter #(.IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .busy       (busy),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_valid   = 1'b0;
      m_idx     = 0;
      m_ptr     = 0;
      m_hold    = 0;
      m_timeout = 1'b0;
   endfunction

   // What the arbiter should do at the coming rising edge given request vector r.
   function automatic void model_edge(input logic [N-1:0] r);
      bit hit;
      m_timeout = 1'b0;
      if (!m_valid) begin
         hit = 1'b0;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!hit && r[i]) begin
               hit   = 1'b1;
               m_idx = i;
            end
         end
         if (hit) begin
            m_valid = 1'b1;
            m_hold  = 0;
         end
      end else if (!r[m_idx]) begin
         m_valid = 1'b0;
         m_ptr   = (m_idx + 1) % N;
      end
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
      else if (m_hold == MAX_HOLD - 1) begin
         m_valid   = 1'b0;
         m_ptr     = (m_idx + 1) % N;
         m_timeout = 1'b1;
      end else begin
         m_hold++;
      end
`endif
   endfunction

   task automatic compare_all();
      check("gnt_valid",  32'(gnt_valid),  32'(m_valid));
      check("gnt_idx",    32'(gnt_idx),    32'(m_idx));
      check("gnt_onehot", 32'(gnt_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
      check("busy",       32'(busy),       32'(m_valid));
      check("timeout",    32'(timeout),    32'(m_timeout));
   endtask

   // Drive r for one edge, then compare on the following falling edge.
   task automatic step(input logic [N-1:0] r);
      req = r;
      model_edge(r);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      int  first_run;
      bit  still;
      bit  seen_to;
      logic [N-1:0] r;

      n_vec = 0;
      n_err = 0;
      req   = '0;
      rst_n = 1'b0;
      model_reset();

      // Reset with every request asserted, then the first grant goes to index 0.
      do_reset();
      check("rst_onehot", 32'(gnt_onehot), 32'h0);
      step(8'hFF);
      check("rst_first_idx", 32'(gnt_idx), 32'd0);
      check("rst_first_oh",  32'(gnt_onehot), 32'h01);
      step(8'h00);
      step(8'h00);

      // Single requester 5.
      step(8'h20);
      check("single_idx", 32'(gnt_idx), 32'd5);
      check("single_oh",  32'(gnt_onehot), 32'h20);
      step(8'h20);
      step(8'h00);
      check("single_rel", 32'(gnt_valid), 32'd0);
      step(8'h00);

      // Full rotation from a fresh pointer with all requests held.
      do_reset();
      for (int g = 0; g <= N; g++) begin
         step(8'hFF);
         check("rot_idx", 32'(gnt_idx), 32'(g % N));
         step(8'hFF);
         step(8'hFF & ~(8'h01 << (g % N)));
         check("rot_gap", 32'(gnt_valid), 32'd0);
      end

      // Wrap from 7 back to 0.
      step(8'h40);
      step(8'h00);
      step(8'h81);
      check("wrap_7", 32'(gnt_idx), 32'd7);
      step(8'h01);
      step(8'h81);
      check("wrap_0", 32'(gnt_idx), 32'd0);
      step(8'h00);

      // Asynchronous reset in the middle of a grant on index 3.
      step(8'h08);
      check("mid_pre_oh", 32'(gnt_onehot), 32'h08);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_rst_oh",    32'(gnt_onehot), 32'h0);
      check("mid_rst_valid", 32'(gnt_valid), 32'd0);
      check("mid_rst_to",    32'(timeout), 32'd0);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // Single requester holding its request.
      step(8'h04);
      first_run = 1;
      still     = 1'b1;
      seen_to   = 1'b0;
      for (int i = 0; i < 110; i++) begin
         step(8'h04);
         if (still && gnt_valid) first_run++;
         else still = 1'b0;
         if (timeout) seen_to = 1'b1;
      end
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
      check("hold_len",  32'(first_run), 32'(MAX_HOLD));
      check("hold_to",   32'(seen_to), 32'd1);
`else
      check("hold_long", 32'(first_run > 100), 32'd1);
      check("hold_to",   32'(seen_to), 32'd0);
`endif
      step(8'h00);
      step(8'h00);

      // Random traffic; usually keep the owner's bit up so grants last a while.
      for (int i = 0; i < 400; i++) begin
         r = N'($urandom);
         if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
         if (m_valid && $urandom_range(0, 3) != 0) r = r | (N'(1) << m_idx);
         if ($urandom_range(0, 9) == 0) r = '0;
         step(r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
